shift_reg_universal: RTL and testbench
======================================

// Module: shift_reg_universal
// PURPOSE
//  Parametrised universal shift register; successor to the fixed 4-bit serial-in shifter.
//  Supports hold, shift L/R, parallel load and rotate L/R, selected per cycle.
//  A shift counter flags each completed WIDTH-bit frame, so the block also works as a deserialiser.
//  Sits between serial links and parallel datapaths in lab designs.
// PARAMETERS
//  WIDTH      4   register width in bits; legal range WIDTH >= 2
//  RESET_VAL  0   value loaded into q on reset; WIDTH bits wide
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  en          in   1           operation enable; 0 = hold everything
//  mode        in   3           operation select (see BEHAVIOUR)
//  sin_r       in   1           serial in, enters at bit 0 on shift-left
//  sin_l       in   1           serial in, enters at bit WIDTH-1 on shift-right
//  d           in   WIDTH       parallel load data
//  q           out  WIDTH       register contents
//  sout_l      out  1           q[WIDTH-1], combinational from the register
//  sout_r      out  1           q[0], combinational from the register
//  cnt         out  CW          shifts since last load/reset; CW = $clog2(WIDTH+1)
//  frame_done  out  1           one-cycle pulse: WIDTH shifts completed
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high. Reset has priority over en and mode.
//  - Reset: q=RESET_VAL, cnt=0, frame_done=0. Values hold from the first edge with reset=1.
//  - mode decode, applied only on an edge with en=1:
//      000 hold     q unchanged
//      001 SL       q <= {q[WIDTH-2:0], sin_r}
//      010 SR       q <= {sin_l, q[WIDTH-1:1]}
//      011 LOAD     q <= d
//      100 ROL      q <= {q[WIDTH-2:0], q[WIDTH-1]}
//      101 ROR      q <= {q[0], q[WIDTH-1:1]}
//      110/111      reserved; behave as hold
//  - en=0: q, cnt unchanged; frame_done=0 on that edge.
//  - Counter:
//      - Each SL/SR/ROL/ROR edge increments cnt.
//      - The edge on which cnt would reach WIDTH sets cnt=0 and frame_done=1.
//      - Frame and q update occur on the same edge, so q holds the full frame while frame_done=1.
//  - LOAD clears cnt to 0 and drives frame_done=0.
//  - Hold/reserved leave cnt unchanged.
//  - frame_done is registered and is 1 for exactly one cycle. The edge after a pulse clears it,
//    unless that edge completes another frame.
//  - Mixed directions (e.g. SL then SR) all count toward the same frame.
//  - Reset mid-frame discards progress; the next frame needs WIDTH fresh shifts.
//  - Latency: q/cnt/frame_done update one edge after inputs are sampled. No combinational
//    path from inputs to outputs.
// TESTING (WIDTH=4, RESET_VAL=0 unless stated)
//  1. reset=1 for 2 edges, mode=011, d=4'hF -> q=0000, cnt=0, frame_done=0 (reset beats load).
//  2. SL en=1, sin_r=1,0,0,1 on 4 edges -> q=0001,0010,0100,1001; frame_done=1 only after
//     the 4th edge, with cnt=0.
//  3. LOAD d=1011, then ROL -> 0111, then ROR x2 -> 1011, 1101; sout_l/sout_r track q[3]/q[0].
//  4. SR, sin_l=1 x4 from 0000 -> 1000,1100,1110,1111; frame_done pulse after the 4th edge.
//     A 5th SR gives cnt=1, frame_done=0.
//  5. 2 shifts, then en=0 with mode=001 for 3 edges -> q and cnt frozen.
//     Then reset, then 3 shifts -> no frame_done (progress discarded).
//  6. 3 shifts, LOAD, 1 shift -> cnt=1, no pulse.
//     mode=110 for 2 edges -> hold.
//     Repeat test 2 with WIDTH=8, RESET_VAL=8'hA5 -> reset q=A5; pulse after the 8th shift.

Source files
------------

// File: rtl/shift_reg_universal.sv
// ============================================================================
// Module      : shift_reg_universal
// Description : Parametrised universal shift register (hold, shift, load,
//               rotate) with a frame counter for deserialiser use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_universal #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  localparam logic [2:0] C_MODE_HOLD = 3'b000;
  localparam logic [2:0] C_MODE_SL   = 3'b001;
  localparam logic [2:0] C_MODE_SR   = 3'b010;
  localparam logic [2:0] C_MODE_LOAD = 3'b011;
  localparam logic [2:0] C_MODE_ROL  = 3'b100;
  localparam logic [2:0] C_MODE_ROR  = 3'b101;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_q_next;
  logic             w_is_shift;
  logic             w_is_load;
  logic             w_cnt_last;

  always_comb begin
    w_q_next   = r_q;
    w_is_shift = 1'b0;
    w_is_load  = 1'b0;
    case (mode)
      C_MODE_HOLD: w_q_next = r_q;
      C_MODE_SL: begin
        w_q_next   = {r_q[WIDTH-2:0], sin_r};
        w_is_shift = 1'b1;
      end
      C_MODE_SR: begin
        w_q_next   = {sin_l, r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      C_MODE_LOAD: begin
        w_q_next  = d;
        w_is_load = 1'b1;
      end
      C_MODE_ROL: begin
        w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_is_shift = 1'b1;
      end
      C_MODE_ROR: begin
        w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      default: w_q_next = r_q;  // reserved encodings hold
    endcase
  end

  assign w_cnt_last = (r_cnt == C_CNT_LAST);

  // The counter wraps on the same edge that shifts in the last bit of a
  // frame, so q holds the complete frame while frame_done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= RESET_VAL;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else if (!en) begin
      r_frame_done <= 1'b0;
    end else begin
      r_q <= w_q_next;
      if (w_is_load) begin
        r_cnt        <= '0;
        r_frame_done <= 1'b0;
      end else if (w_is_shift) begin
        if (w_cnt_last) begin
          r_cnt        <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_cnt        <= r_cnt + C_CNT_ONE;
          r_frame_done <= 1'b0;
        end
      end else begin
        r_frame_done <= 1'b0;
      end
    end
  end

  assign q          = r_q;
  assign sout_l     = r_q[WIDTH-1];
  assign sout_r     = r_q[0];
  assign cnt        = r_cnt;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
// ============================================================================
// Module      : tb_shift_reg_universal
// Description : Directed self-checking bench for shift_reg_universal
//               (WIDTH=4 default instance and WIDTH=8 / RESET_VAL=A5 instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_universal;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [3:0] d4;
  logic [7:0] d8;

  logic [3:0] q4;
  logic       sout_l4, sout_r4, fd4;
  logic [2:0] cnt4;
  logic [7:0] q8;
  logic       sout_l8, sout_r8, fd8;
  logic [3:0] cnt8;

  int n_checks = 0;
  int n_errors = 0;

  shift_reg_universal u_dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .d(d4),
    .q(q4), .sout_l(sout_l4), .sout_r(sout_r4), .cnt(cnt4), .frame_done(fd4)
  );

  shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .d(d8),
    .q(q8), .sout_l(sout_l8), .sout_r(sout_r8), .cnt(cnt8), .frame_done(fd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 ns before sampling.
  task automatic step(input logic rst_i, input logic en_i, input logic [2:0] mode_i,
                      input logic sr_i, input logic sl_i, input logic [3:0] d_i);
    reset = rst_i; en = en_i; mode = mode_i; sin_r = sr_i; sin_l = sl_i; d4 = d_i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic [2:0] ec, input logic ef);
    check({tag, ".q"},   32'(q4),   32'(eq));
    check({tag, ".cnt"}, 32'(cnt4), 32'(ec));
    check({tag, ".fd"},  32'(fd4),  32'(ef));
  endtask

  localparam logic [3:0] SL_BITS4 = 4'b1001;  // sin_r sequence 1,0,0,1 (MSB first)
  localparam logic [7:0] SL_BITS8 = 8'b10011010;

  initial begin
    logic [3:0] sl_bits4;
    logic [3:0] exp_q4 [4];
    logic [7:0] sl_bits8;
    logic [7:0] exp_q8 [8];
    sl_bits4 = SL_BITS4;
    sl_bits8 = SL_BITS8;
    exp_q4 = '{4'h1, 4'h2, 4'h4, 4'h9};
    exp_q8 = '{8'h4B, 8'h96, 8'h2C, 8'h59, 8'hB3, 8'h66, 8'hCD, 8'h9A};
    reset = 1'b1; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0; d4 = '0; d8 = 8'hFF;

    // Reset beats load
    step(1, 1, 3'b011, 0, 0, 4'hF);
    step(1, 1, 3'b011, 0, 0, 4'hF);
    chk4("reset", 4'h0, 3'd0, 1'b0);
    check("reset8.q", 32'(q8), 32'hA5);
    check("reset8.cnt", 32'(cnt8), 32'd0);

    // Shift left 1,0,0,1
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 3'b001, sl_bits4[3-i], 0, 4'h0);
      chk4($sformatf("sl%0d", i), exp_q4[i], (i == 3) ? 3'd0 : 3'(i + 1), (i == 3));
    end
    step(0, 1, 3'b000, 0, 0, 4'h0);
    chk4("sl_hold", 4'h9, 3'd0, 1'b0);

    // Load, rotate left, rotate right x2
    step(0, 1, 3'b011, 0, 0, 4'hB);
    chk4("load", 4'hB, 3'd0, 1'b0);
    step(0, 1, 3'b100, 0, 0, 4'h0);
    chk4("rol", 4'h7, 3'd1, 1'b0);
    check("rol.sout_l", 32'(sout_l4), 32'd0);
    check("rol.sout_r", 32'(sout_r4), 32'd1);
    step(0, 1, 3'b101, 0, 0, 4'h0);
    chk4("ror1", 4'hB, 3'd2, 1'b0);
    step(0, 1, 3'b101, 0, 0, 4'h0);
    chk4("ror2", 4'hD, 3'd3, 1'b0);
    check("ror2.sout_l", 32'(sout_l4), 32'd1);
    check("ror2.sout_r", 32'(sout_r4), 32'd1);

    // Shift right with sin_l=1 from zero, plus one extra shift
    step(0, 1, 3'b011, 0, 0, 4'h0);
    step(0, 1, 3'b010, 0, 1, 4'h0); chk4("sr1", 4'h8, 3'd1, 1'b0);
    step(0, 1, 3'b010, 0, 1, 4'h0); chk4("sr2", 4'hC, 3'd2, 1'b0);
    step(0, 1, 3'b010, 0, 1, 4'h0); chk4("sr3", 4'hE, 3'd3, 1'b0);
    step(0, 1, 3'b010, 0, 1, 4'h0); chk4("sr4", 4'hF, 3'd0, 1'b1);
    step(0, 1, 3'b010, 0, 1, 4'h0); chk4("sr5", 4'hF, 3'd1, 1'b0);

    // Enable low freezes state; reset discards frame progress
    step(0, 1, 3'b011, 0, 0, 4'h0);
    step(0, 1, 3'b001, 1, 0, 4'h0);
    step(0, 1, 3'b001, 1, 0, 4'h0);
    chk4("pre_en0", 4'h3, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'b001, 1, 0, 4'h0);
      chk4($sformatf("en0_%0d", i), 4'h3, 3'd2, 1'b0);
    end
    step(1, 1, 3'b001, 1, 0, 4'h0);
    chk4("mid_reset", 4'h0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'b001, 0, 0, 4'h0);
      chk4($sformatf("post_rst%0d", i), 4'h0, 3'(i + 1), 1'b0);
    end
    step(0, 1, 3'b001, 0, 0, 4'h0);
    chk4("post_rst3", 4'h0, 3'd0, 1'b1);

    // Load mid-frame clears the count; reserved modes hold
    step(0, 1, 3'b001, 0, 0, 4'h0);
    step(0, 1, 3'b001, 0, 0, 4'h0);
    step(0, 1, 3'b001, 0, 0, 4'h0);
    check("pre_load.cnt", 32'(cnt4), 32'd3);
    step(0, 1, 3'b011, 0, 0, 4'h5);
    chk4("mid_load", 4'h5, 3'd0, 1'b0);
    step(0, 1, 3'b001, 0, 0, 4'h0);
    chk4("load_sl", 4'hA, 3'd1, 1'b0);
    step(0, 1, 3'b110, 1, 1, 4'hF); chk4("rsv110a", 4'hA, 3'd1, 1'b0);
    step(0, 1, 3'b110, 1, 1, 4'hF); chk4("rsv110b", 4'hA, 3'd1, 1'b0);
    step(0, 1, 3'b111, 1, 1, 4'hF); chk4("rsv111",  4'hA, 3'd1, 1'b0);

    // Mixed directions share one frame
    step(0, 1, 3'b010, 0, 0, 4'h0); chk4("mix_sr",  4'h5, 3'd2, 1'b0);
    step(0, 1, 3'b100, 0, 0, 4'h0); chk4("mix_rol", 4'hA, 3'd3, 1'b0);
    step(0, 1, 3'b101, 0, 0, 4'h0); chk4("mix_ror", 4'h5, 3'd0, 1'b1);

    // Wide instance: reset value then an 8-bit serial frame
    step(1, 1, 3'b000, 0, 0, 4'h0);
    check("w8_reset.q", 32'(q8), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'b001, sl_bits8[7-i], 0, 4'h0);
      check($sformatf("w8_sl%0d.q", i), 32'(q8), 32'(exp_q8[i]));
      check($sformatf("w8_sl%0d.cnt", i), 32'(cnt8), (i == 7) ? 32'd0 : 32'(i + 1));
      check($sformatf("w8_sl%0d.fd", i), 32'(fd8), (i == 7) ? 32'd1 : 32'd0);
    end
    check("w8.sout_l", 32'(sout_l8), 32'd1);
    check("w8.sout_r", 32'(sout_r8), 32'd0);
    step(0, 1, 3'b000, 0, 0, 4'h0);
    check("w8_after.fd", 32'(fd8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
